// File: rtl/count_ser_pkg.sv
// Shared types and constants for the count serializer.
// Frame length depends on the SER_PARITY_EN build macro (adds an even-parity bit).
package count_ser_pkg;

    localparam int DATA_W = 8;

`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif

    // Width of the bit index inside a frame (0 .. FRAME_LEN-1).
    localparam int BIT_W = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/count_ser_fifo.sv
// Small synchronous FIFO buffering count words ahead of the serializer.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module count_ser_fifo
    import count_ser_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Guard against over/underflow even if a caller misbehaves.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next pointer and occupancy; push+pop together leaves the count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset empties the FIFO logically.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/count_serializer.sv
// Count serializer: buffers 8-bit count words and shifts them out MSB first
// on a divided serial clock, with ser_frame marking each frame.
// Build macro SER_PARITY_EN appends an even-parity bit to each frame.
module count_serializer
    import count_ser_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  DIV   = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_clk,
    output logic              ser_data,
    output logic              ser_frame,
    output logic              busy,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              ovf,
    output state_e            state_dbg
);

    // One bit period is 2*DIV cycles: ser_clk low for the first half, high for the second.
    localparam int             PER      = 2 * DIV;
    localparam int             PH_W     = $clog2(PER);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PER - 1);
    localparam logic [PH_W-1:0] PH_HALF  = PH_W'(DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_LEN - 1);

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;

    state_e                 state_q, state_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [FRAME_LEN-1:0]   sreg_q, sreg_d;
    logic                   ser_clk_q, ser_clk_d;
    logic                   ser_data_q, ser_data_d;
    logic                   ser_frame_q, ser_frame_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;

    // Handshake: a word transfers on a posedge where in_valid and in_ready are
    // both high; in_ready depends only on registered occupancy, never on in_valid,
    // and a word offered while in_ready is low is dropped and flagged in ovf.
    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & in_ready;
    // LOAD is only entered with a non-empty FIFO, so it always pops a real word.
    assign fifo_pop  = (state_q == ST_LOAD);

    count_ser_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state, timing counters, shift register and registered outputs.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                phase_d = '0;
                bit_d   = '0;
`ifdef SER_PARITY_EN
                sreg_d  = {fifo_head, ^fifo_head};
`else
                sreg_d  = fifo_head;
`endif
            end
            ST_SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_GAP;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        sreg_d = {sreg_q[FRAME_LEN-2:0], 1'b0};
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_GAP: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = fifo_empty ? ST_IDLE : ST_LOAD;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from the next state so they are glitch-free flops.
        ser_frame_d = (state_d == ST_SHIFT);
        ser_clk_d   = (state_d == ST_SHIFT) && (phase_d >= PH_HALF);
        ser_data_d  = (state_d == ST_SHIFT) ? sreg_d[FRAME_LEN-1] : 1'b0;
        busy_d      = (state_d != ST_IDLE);
        ovf_d       = ovf_q | (in_valid & fifo_full);
    end

    // FSM and output registers with synchronous reset (aborts any frame).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            sreg_q      <= '0;
            ser_clk_q   <= 1'b0;
            ser_data_q  <= 1'b0;
            ser_frame_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            sreg_q      <= sreg_d;
            ser_clk_q   <= ser_clk_d;
            ser_data_q  <= ser_data_d;
            ser_frame_q <= ser_frame_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ser_clk   = ser_clk_q;
    assign ser_data  = ser_data_q;
    assign ser_frame = ser_frame_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_count_serializer.sv
// Directed bench for count_serializer (DEPTH=4, DIV=2).
// A monitor captures each frame (bits on ser_clk rising edges, start cycle,
// length); the main sequence compares against hand-computed expectations.
module tb_count_serializer;
    import count_ser_pkg::*;

`ifdef SER_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ser_clk;
    logic       ser_data;
    logic       ser_frame;
    logic       busy;
    logic [2:0] fifo_count;
    logic       ovf;
    state_e     state_dbg;

    count_serializer #(
        .DEPTH (4),
        .DIV   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_clk    (ser_clk),
        .ser_data   (ser_data),
        .ser_frame  (ser_frame),
        .busy       (busy),
        .fifo_count (fifo_count),
        .ovf        (ovf),
        .state_dbg  (state_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [8:0] got_q[$];
    int         nbits_q[$];
    int         start_q[$];
    int         len_q[$];
    int         rises = 0;
    int         viol = 0;
    logic       prev_frame = 1'b0;
    logic       prev_sclk = 1'b0;
    logic       prev_data = 1'b0;
    logic [8:0] cur_word = '0;
    int         cur_bits = 0;
    int         frame_start = 0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            cur_word = '0;
            cur_bits = 0;
        end else begin
            if (ser_frame && !prev_frame) begin
                frame_start = cyc;
                cur_word = '0;
                cur_bits = 0;
                rises++;
            end
            if (ser_frame && ser_clk && !prev_sclk) begin
                cur_word = {cur_word[7:0], ser_data};
                cur_bits++;
            end
            // Data may only move at the start of a bit (clock just fell low).
            if (ser_frame && prev_frame && (ser_data != prev_data) && !(!ser_clk && prev_sclk))
                viol++;
            if (!ser_frame && (ser_data || ser_clk))
                viol++;
            if (!ser_frame && prev_frame) begin
                got_q.push_back(cur_word);
                nbits_q.push_back(cur_bits);
                start_q.push_back(frame_start);
                len_q.push_back(cyc - frame_start);
            end
        end
        prev_frame = rst ? 1'b0 : ser_frame;
        prev_sclk  = rst ? 1'b0 : ser_clk;
        prev_data  = rst ? 1'b0 : ser_data;
    end

    // ---------------- scoreboard / checks ----------------
    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic clear_mon();
        got_q.delete();
        nbits_q.delete();
        start_q.delete();
        len_q.delete();
        rises = 0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("frames_seen", got_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        chk("reach_idle", busy, 1'b0);
    endtask

    task automatic check_frames(input string tag, input int n);
        for (int i = 0; i < n && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            chk({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
            chk({tag, "_nbits"}, nbits_q.pop_front(), FLEN);
            chk({tag, "_len"}, len_q.pop_front(), FLEN * 4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        int e0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) tick();

        // Reset values.
        chk("rst_ser_clk",   ser_clk, 1'b0);
        chk("rst_ser_data",  ser_data, 1'b0);
        chk("rst_ser_frame", ser_frame, 1'b0);
        chk("rst_busy",      busy, 1'b0);
        chk("rst_count",     fifo_count, 3'd0);
        chk("rst_ovf",       ovf, 1'b0);
        chk("rst_state",     state_dbg, ST_IDLE);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", in_ready, 1'b1);

        // Single word 8'hA5: latency, bit order, frame and gap length.
        clear_mon();
        push_word(8'hA5);
        acc = cyc;
        chk("a5_count_after_push", fifo_count, 3'd1);
        chk("a5_state_idle", state_dbg, ST_IDLE);
        tick();
        chk("a5_state_load", state_dbg, ST_LOAD);
        chk("a5_busy_load", busy, 1'b1);
        chk("a5_frame_load", ser_frame, 1'b0);
        tick();
        chk("a5_frame_up", ser_frame, 1'b1);
        chk("a5_msb", ser_data, 1'b1);
        chk("a5_sclk_low", ser_clk, 1'b0);
        chk("a5_count_popped", fifo_count, 3'd0);
        wait_frames(1, 100);
        if (start_q.size() > 0) chk("a5_latency", start_q[0] - acc, 2);
        exp_q.push_back(9'h0A5);
        check_frames("a5", 1);
        chk("a5_state_gap", state_dbg, ST_GAP);
        repeat (3) tick();
        chk("a5_gap_busy", busy, 1'b1);
        tick();
        chk("a5_gap_done", busy, 1'b0);
        chk("a5_state_end", state_dbg, ST_IDLE);

        // Back-to-back 01,02,03; third push coincides with the LOAD pop at count 2.
        clear_mon();
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        chk("b2b_push_pop_count", fifo_count, 3'd2);
        wait_frames(3, 300);
        if (start_q.size() == 3) begin
            chk("b2b_spacing_01", start_q[1] - (start_q[0] + len_q[0]), 5);
            chk("b2b_spacing_12", start_q[2] - (start_q[1] + len_q[1]), 5);
        end
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h002);
        exp_q.push_back(9'h003);
        check_frames("b2b", 3);
        wait_idle(50);

        // Overflow: one word in flight, then six pushes into a DEPTH=4 FIFO.
        clear_mon();
        push_word(8'h30);
        tick();
        tick();
        chk("ovf_busy", busy, 1'b1);
        push_word(8'h31);
        push_word(8'h32);
        push_word(8'h33);
        chk("ovf_ready_before_full", in_ready, 1'b1);
        push_word(8'h34);
        chk("ovf_ready_low", in_ready, 1'b0);
        chk("ovf_count_full", fifo_count, 3'd4);
        chk("ovf_not_yet", ovf, 1'b0);
        push_word(8'h35);
        chk("ovf_set", ovf, 1'b1);
        chk("ovf_count_kept", fifo_count, 3'd4);
        push_word(8'h36);
        chk("ovf_count_kept2", fifo_count, 3'd4);
        wait_frames(5, 400);
        exp_q.push_back(9'h030);
        exp_q.push_back(9'h031);
        exp_q.push_back(9'h032);
        exp_q.push_back(9'h033);
        exp_q.push_back(9'h034);
        check_frames("ovf", 5);
        wait_idle(100);
        chk("ovf_no_extra_frames", got_q.size(), 0);
        chk("ovf_sticky", ovf, 1'b1);

        // Reset mid-frame: 8'hFF in flight with 8'hAA queued.
        clear_mon();
        push_word(8'hFF);
        push_word(8'hAA);
        tick();
        chk("mrst_frame_up", ser_frame, 1'b1);
        repeat (18) tick();
        chk("mrst_in_bit4_high", ser_clk, 1'b1);
        chk("mrst_queued", fifo_count, 3'd1);
        rst = 1'b1;
        tick();
        chk("mrst_frame", ser_frame, 1'b0);
        chk("mrst_sclk", ser_clk, 1'b0);
        chk("mrst_count", fifo_count, 3'd0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_ovf_clear", ovf, 1'b0);
        rst = 1'b0;
        clear_mon();
        repeat (40) tick();
        chk("mrst_no_residual", rises, 0);
        chk("mrst_still_idle", busy, 1'b0);
        chk("mrst_ready", in_ready, 1'b1);

        // Frame format: 8'h07 and 8'h03 (parity bits 1 and 0 when enabled).
        clear_mon();
        push_word(8'h07);
        push_word(8'h03);
        wait_frames(2, 200);
`ifdef SER_PARITY_EN
        exp_q.push_back(9'h00F);
        exp_q.push_back(9'h006);
`else
        exp_q.push_back(9'h007);
        exp_q.push_back(9'h003);
`endif
        check_frames("fmt", 2);
        wait_idle(50);

        chk("data_timing_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
